// File: rtl/monolith_job_sched.sv
// Job scheduler feeding the Monolith hash core: canonicalising job FIFO, single-job
// issue FSM with a watchdog, and a result FIFO drained over a valid/ready stream.
//
// state | meaning
// IDLE  | waiting for a queued job and a free result slot
// ISSUE | core_start pulse, watchdog cleared
// WAIT  | waiting for core_valid or watchdog expiry
module monolith_job_sched #(
    parameter int JOB_DEPTH = 4,
    parameter int RES_DEPTH = 4,
    parameter int TIMEOUT   = 1024
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [61:0] in_data,
    output logic        core_start,
    output logic [30:0] core_in1,
    output logic [30:0] core_in2,
    input  logic        core_valid,
    input  logic [30:0] core_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [30:0] out_data,
    output logic        irq,
    output logic        err,
    input  logic        err_clr,
    output logic [15:0] jobs_done
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    localparam int JAW = $clog2(JOB_DEPTH);
    localparam int RAW = $clog2(RES_DEPTH);
    localparam int WDW = $clog2(TIMEOUT);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);
    localparam logic [30:0] M31_P = 31'h7FFF_FFFF;

    state_t         state;
    logic [WDW-1:0] wdog;

    logic [61:0]    job_mem [JOB_DEPTH];
    logic [JAW:0]   job_wp, job_rp, job_wp_n, job_rp_n;
    logic [61:0]    job_head;
    logic           job_push, job_pop, job_empty, job_full_n;

    logic [30:0]    res_mem [RES_DEPTH];
    logic [RAW:0]   res_wp, res_rp, res_wp_n, res_rp_n;
    logic           res_push, res_pop, res_full, out_valid_n;

    function automatic logic [30:0] canon(input logic [30:0] v);
        return (v == M31_P) ? 31'd0 : v;
    endfunction

    assign job_empty   = (job_wp == job_rp);
    assign res_full    = (res_wp[RAW] != res_rp[RAW]) && (res_wp[RAW-1:0] == res_rp[RAW-1:0]);
    assign job_head    = job_mem[job_rp[JAW-1:0]];

    // A result slot is reserved at issue time, so WAIT can always push.
    assign job_push    = in_valid && in_ready;
    assign job_pop     = (state == S_IDLE) && !job_empty && !res_full;
    assign res_push    = (state == S_WAIT) && core_valid;
    assign res_pop     = out_valid && out_ready;

    assign job_wp_n    = job_wp + (JAW+1)'(job_push);
    assign job_rp_n    = job_rp + (JAW+1)'(job_pop);
    assign res_wp_n    = res_wp + (RAW+1)'(res_push);
    assign res_rp_n    = res_rp + (RAW+1)'(res_pop);

    assign job_full_n  = (job_wp_n[JAW] != job_rp_n[JAW]) &&
                         (job_wp_n[JAW-1:0] == job_rp_n[JAW-1:0]);
    assign out_valid_n = (res_wp_n != res_rp_n);

    assign irq = out_valid;

    always_ff @(posedge aclk) begin
        if (job_push) begin
            job_mem[job_wp[JAW-1:0]] <= {canon(in_data[61:31]), canon(in_data[30:0])};
        end
        if (res_push) begin
            res_mem[res_wp[RAW-1:0]] <= core_out;
        end
    end

    // Flags and head data are registered from next-state pointers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            job_wp    <= '0;
            job_rp    <= '0;
            res_wp    <= '0;
            res_rp    <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            job_wp    <= job_wp_n;
            job_rp    <= job_rp_n;
            res_wp    <= res_wp_n;
            res_rp    <= res_rp_n;
            in_ready  <= !job_full_n;
            out_valid <= out_valid_n;
            if (out_valid_n) begin
                // The next head is the incoming digest when it lands in the head slot.
                if (res_push && (res_wp[RAW-1:0] == res_rp_n[RAW-1:0])) begin
                    out_data <= core_out;
                end else begin
                    out_data <= res_mem[res_rp_n[RAW-1:0]];
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= S_IDLE;
            core_start <= 1'b0;
            core_in1   <= '0;
            core_in2   <= '0;
            wdog       <= '0;
            err        <= 1'b0;
            jobs_done  <= '0;
        end else begin
            core_start <= 1'b0;
            if (err_clr) begin
                err <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (job_pop) begin
                        core_in1   <= job_head[30:0];
                        core_in2   <= job_head[61:31];
                        core_start <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wdog  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_valid) begin
                        jobs_done <= jobs_done + 16'd1;
                        state     <= S_IDLE;
                    end else if (wdog == WD_LAST) begin
                        err   <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_monolith_job_sched.sv
// Directed bench for monolith_job_sched with a negedge-driven core model.
module tb_monolith_job_sched;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        in_valid = 1'b0;
    logic [61:0] in_data = '0;
    logic        core_valid = 1'b0;
    logic [30:0] core_out = '0;
    logic        out_ready = 1'b0;
    logic        err_clr = 1'b0;
    logic        in_ready, core_start, out_valid, irq, err;
    logic [30:0] core_in1, core_in2, out_data;
    logic [15:0] jobs_done;

    int n_checks = 0;
    int n_fail = 0;

    int          lat = 0;       // 0: core never responds
    int          cnt = 0;
    int          n_start = 0;
    logic [30:0] dig_add = '0;
    logic [30:0] st_in1 = '0;

    monolith_job_sched #(.JOB_DEPTH(4), .RES_DEPTH(4), .TIMEOUT(16)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .core_start(core_start), .core_in1(core_in1), .core_in2(core_in2),
        .core_valid(core_valid), .core_out(core_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .irq(irq), .err(err), .err_clr(err_clr), .jobs_done(jobs_done)
    );

    always #5 aclk = ~aclk;

    // Core model: clears valid on start, raises it lat cycles later with in1 + dig_add.
    always @(negedge aclk) begin
        if (core_start) begin
            n_start++;
            st_in1 = core_in1;
            core_valid = 1'b0;
            cnt = lat;
        end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                core_valid = 1'b1;
                core_out = st_in1 + dig_add;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish, time %0t required below 300000", $time);
        $fatal(1);
    end

    task automatic offer(input logic [30:0] e2, input logic [30:0] e1);
        int i = 0;
        in_valid = 1'b1;
        in_data = {e2, e1};
        while (in_ready !== 1'b1 && i < 100) begin @(negedge aclk); i++; end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL offer_accept: in_ready %b required 1 for job %h", in_ready, {e2, e1}); end
        @(negedge aclk);
        in_valid = 1'b0;
    endtask

    task automatic wait_start(input string name);
        bit seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge aclk);
            if (core_start === 1'b1) seen = 1;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL %s_start: no core_start within 10 cycles, required one", name); end
    endtask

    task automatic pop_one(output logic [30:0] d, output bit ok);
        int i = 0;
        while (out_valid !== 1'b1 && i < 100) begin @(negedge aclk); i++; end
        ok = (out_valid === 1'b1);
        d = out_data;
        out_ready = 1'b1;
        @(negedge aclk);
        out_ready = 1'b0;
    endtask

    task automatic drain_expect(input string name, input int first, input int num);
        int idx = 0;
        int i = 0;
        out_ready = 1'b1;
        while (idx < num && i < 200) begin
            if (out_valid === 1'b1) begin
                n_checks++;
                if (out_data !== 31'(first + idx)) begin n_fail++; $display("FAIL %s_order[%0d]: out_data %0d required %0d", name, idx, out_data, first + idx); end
                idx++;
            end
            @(negedge aclk);
            i++;
        end
        out_ready = 1'b0;
        n_checks++;
        if (idx != num) begin n_fail++; $display("FAIL %s_count: %0d results drained, required %0d", name, idx, num); end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (2) @(negedge aclk);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: %b required 0", in_ready); end
        n_checks++; if (core_start !== 1'b0) begin n_fail++; $display("FAIL rst_core_start: %b required 0", core_start); end
        n_checks++; if (core_in1 !== 31'd0 || core_in2 !== 31'd0) begin n_fail++; $display("FAIL rst_core_in: %h/%h required 0/0", core_in1, core_in2); end
        n_checks++; if (out_valid !== 1'b0 || irq !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: %b irq %b required 0", out_valid, irq); end
        n_checks++; if (out_data !== 31'd0) begin n_fail++; $display("FAIL rst_out_data: %h required 0", out_data); end
        n_checks++; if (err !== 1'b0 || jobs_done !== 16'd0) begin n_fail++; $display("FAIL rst_err_cnt: err %b jobs_done %0d required 0/0", err, jobs_done); end
        aresetn = 1'b1;
        @(negedge aclk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: %b required 1", in_ready); end
    endtask

    task automatic test_single();
        int n = 0;
        int s0 = n_start;
        lat = 10;
        dig_add = 31'h1234 - 31'd54;
        offer(31'd0, 31'd54);
        @(negedge aclk);
        n_checks++; if (core_start !== 1'b1) begin n_fail++; $display("FAIL single_start_timing: core_start %b required 1", core_start); end
        n_checks++; if (core_in1 !== 31'd54 || core_in2 !== 31'd0) begin n_fail++; $display("FAIL single_core_in: %0d/%0d required 54/0", core_in1, core_in2); end
        @(negedge aclk);
        n_checks++; if (core_start !== 1'b0) begin n_fail++; $display("FAIL single_start_width: core_start %b required 0", core_start); end
        n = 1;
        while (out_valid !== 1'b1 && n < 60) begin @(negedge aclk); n++; end
        n_checks++; if (n != 11) begin n_fail++; $display("FAIL single_latency: out_valid after %0d cycles, required 11", n); end
        n_checks++; if (out_data !== 31'h1234 || irq !== 1'b1) begin n_fail++; $display("FAIL single_result: out_data %h irq %b required 1234/1", out_data, irq); end
        n_checks++; if (jobs_done !== 16'd1) begin n_fail++; $display("FAIL single_jobs_done: %0d required 1", jobs_done); end
        repeat (3) @(negedge aclk);
        n_checks++; if (out_data !== 31'h1234 || irq !== 1'b1) begin n_fail++; $display("FAIL single_hold: out_data %h irq %b required 1234/1", out_data, irq); end
        out_ready = 1'b1;
        @(negedge aclk);
        out_ready = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || irq !== 1'b0) begin n_fail++; $display("FAIL single_pop: out_valid %b irq %b required 0/0", out_valid, irq); end
        n_checks++; if (n_start - s0 != 1) begin n_fail++; $display("FAIL single_start_count: %0d starts required 1", n_start - s0); end
    endtask

    task automatic test_canon();
        logic [30:0] d;
        bit ok;
        lat = 2;
        dig_add = '0;
        offer(31'h7FFF_FFFE, 31'h7FFF_FFFF);
        wait_start("canon_a");
        n_checks++; if (core_in1 !== 31'd0 || core_in2 !== 31'h7FFF_FFFE) begin n_fail++; $display("FAIL canon_a: %h/%h required 0/7ffffffe", core_in1, core_in2); end
        pop_one(d, ok);
        n_checks++; if (!ok || d !== 31'd0) begin n_fail++; $display("FAIL canon_a_result: ok %b data %h required 1/0", ok, d); end
        offer(31'h7FFF_FFFF, 31'd5);
        wait_start("canon_b");
        n_checks++; if (core_in1 !== 31'd5 || core_in2 !== 31'd0) begin n_fail++; $display("FAIL canon_b: %h/%h required 5/0", core_in1, core_in2); end
        pop_one(d, ok);
        n_checks++; if (!ok || d !== 31'd5) begin n_fail++; $display("FAIL canon_b_result: ok %b data %h required 1/5", ok, d); end
    endtask

    task automatic test_backpressure();
        int s0 = n_start;
        logic [15:0] j0 = jobs_done;
        lat = 5;
        dig_add = '0;
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) offer(31'd0, 31'(54 + k));
        repeat (80) @(negedge aclk);
        n_checks++; if (n_start - s0 != 4) begin n_fail++; $display("FAIL bp_starts_while_full: %0d starts required 4", n_start - s0); end
        n_checks++; if (jobs_done !== j0 + 16'd4 || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_queued: jobs_done %0d out_valid %b required %0d/1", jobs_done, out_valid, j0 + 16'd4); end
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready: %b required 1", in_ready); end
        drain_expect("bp", 54, 5);
        n_checks++; if (n_start - s0 != 5 || jobs_done !== j0 + 16'd5) begin n_fail++; $display("FAIL bp_totals: starts %0d jobs_done %0d required 5/%0d", n_start - s0, jobs_done, j0 + 16'd5); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: out_valid %b required 0", out_valid); end
    endtask

    task automatic test_job_full();
        lat = 8;
        dig_add = '0;
        out_ready = 1'b0;
        offer(31'd0, 31'd100);
        wait_start("full");
        for (int k = 0; k < 4; k++) offer(31'd0, 31'(101 + k));
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: %b required 0 after 4 queued", in_ready); end
        in_valid = 1'b1;
        in_data = {31'd0, 31'd105};
        @(negedge aclk);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_hold_1: in_ready %b required 0", in_ready); end
        @(negedge aclk);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_hold_2: in_ready %b required 0", in_ready); end
        offer(31'd0, 31'd105);
        drain_expect("full", 100, 6);
    endtask

    task automatic test_timeout();
        int n;
        logic [15:0] j0 = jobs_done;
        logic [30:0] d;
        bit ok;
        out_ready = 1'b0;
        lat = 0;
        offer(31'd0, 31'd200);
        @(negedge aclk);
        n_checks++; if (core_start !== 1'b1 || core_in1 !== 31'd200) begin n_fail++; $display("FAIL to_start: core_start %b in1 %0d required 1/200", core_start, core_in1); end
        @(negedge aclk);
        lat = 3;
        in_valid = 1'b1;
        in_data = {31'd0, 31'd201};
        @(negedge aclk);
        in_valid = 1'b0;
        n = 2;
        while (err !== 1'b1 && n < 60) begin @(negedge aclk); n++; end
        n_checks++; if (n != 17) begin n_fail++; $display("FAIL to_err_timing: err after %0d cycles required 17", n); end
        n_checks++; if (out_valid !== 1'b0 || jobs_done !== j0) begin n_fail++; $display("FAIL to_no_push: out_valid %b jobs_done %0d required 0/%0d", out_valid, jobs_done, j0); end
        wait_start("to_next");
        n_checks++; if (core_in1 !== 31'd201) begin n_fail++; $display("FAIL to_next_job: in1 %0d required 201", core_in1); end
        pop_one(d, ok);
        n_checks++; if (!ok || d !== 31'd201 || jobs_done !== j0 + 16'd1) begin n_fail++; $display("FAIL to_next_result: ok %b data %0d jobs_done %0d required 1/201/%0d", ok, d, jobs_done, j0 + 16'd1); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL to_sticky: err %b required 1", err); end
        err_clr = 1'b1;
        @(negedge aclk);
        err_clr = 1'b0;
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL to_clear: err %b required 0", err); end
        lat = 0;
        offer(31'd0, 31'd202);
        @(negedge aclk);
        n_checks++; if (core_start !== 1'b1) begin n_fail++; $display("FAIL to2_start: core_start %b required 1", core_start); end
        repeat (16) @(negedge aclk);
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL to2_early: err %b required 0", err); end
        err_clr = 1'b1;
        @(negedge aclk);
        err_clr = 1'b0;
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL to2_set_wins: err %b required 1", err); end
        @(negedge aclk);
        n_checks++; if (err !== 1'b1 || jobs_done !== j0 + 16'd1) begin n_fail++; $display("FAIL to2_after: err %b jobs_done %0d required 1/%0d", err, jobs_done, j0 + 16'd1); end
        err_clr = 1'b1;
        @(negedge aclk);
        err_clr = 1'b0;
    endtask

    task automatic test_reset_mid();
        int i = 0;
        int s0;
        out_ready = 1'b0;
        lat = 2;
        dig_add = '0;
        offer(31'd0, 31'd299);
        while (out_valid !== 1'b1 && i < 50) begin @(negedge aclk); i++; end
        lat = 0;
        offer(31'd0, 31'd300);
        offer(31'd0, 31'd301);
        offer(31'd0, 31'd302);
        repeat (3) @(negedge aclk);
        #2 aresetn = 1'b0;
        #1;
        n_checks++; if (in_ready !== 1'b0 || core_start !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ctrl: in_ready %b core_start %b required 0/0", in_ready, core_start); end
        n_checks++; if (core_in1 !== 31'd0 || core_in2 !== 31'd0) begin n_fail++; $display("FAIL mid_rst_core_in: %0d/%0d required 0/0", core_in1, core_in2); end
        n_checks++; if (out_valid !== 1'b0 || irq !== 1'b0 || out_data !== 31'd0) begin n_fail++; $display("FAIL mid_rst_out: valid %b irq %b data %0d required 0/0/0", out_valid, irq, out_data); end
        n_checks++; if (err !== 1'b0 || jobs_done !== 16'd0) begin n_fail++; $display("FAIL mid_rst_err_cnt: err %b jobs_done %0d required 0/0", err, jobs_done); end
        @(negedge aclk);
        aresetn = 1'b1;
        s0 = n_start;
        repeat (20) @(negedge aclk);
        n_checks++; if (n_start != s0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_after_release: starts %0d out_valid %b required 0/0", n_start - s0, out_valid); end
        n_checks++; if (in_ready !== 1'b1 || jobs_done !== 16'd0) begin n_fail++; $display("FAIL mid_after_state: in_ready %b jobs_done %0d required 1/0", in_ready, jobs_done); end
    endtask

    task automatic test_wrap();
        logic [30:0] d;
        bit ok;
        force dut.jobs_done = 16'hFFFF;
        @(negedge aclk);
        release dut.jobs_done;
        @(negedge aclk);
        n_checks++; if (jobs_done !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload: jobs_done %h required ffff", jobs_done); end
        lat = 2;
        dig_add = '0;
        offer(31'd0, 31'd400);
        pop_one(d, ok);
        n_checks++; if (!ok || d !== 31'd400) begin n_fail++; $display("FAIL wrap_result: ok %b data %0d required 1/400", ok, d); end
        n_checks++; if (jobs_done !== 16'd0) begin n_fail++; $display("FAIL wrap_count: jobs_done %h required 0", jobs_done); end
    endtask

    task automatic test_reset_during_start();
        lat = 0;
        offer(31'd0, 31'd500);
        @(negedge aclk);
        n_checks++; if (core_start !== 1'b1) begin n_fail++; $display("FAIL rs_start: core_start %b required 1", core_start); end
        #2 aresetn = 1'b0;
        #1;
        n_checks++; if (core_start !== 1'b0 || core_in1 !== 31'd0) begin n_fail++; $display("FAIL rs_async_drop: core_start %b in1 %0d required 0/0", core_start, core_in1); end
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        n_checks++; if (in_ready !== 1'b1 || core_start !== 1'b0) begin n_fail++; $display("FAIL rs_release: in_ready %b core_start %b required 1/0", in_ready, core_start); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_canon();
        test_backpressure();
        test_job_full();
        test_timeout();
        test_reset_mid();
        test_wrap();
        test_reset_during_start();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
